// File: rtl/song_address_sequencer_if.sv
// Control/datapath bundle between the song FSM side and the address sequencer.
// The master drives the controls and the slave returns address and status.
interface song_address_sequencer_if #(
  parameter int ADDR_W = 19,
  parameter int SLOT_W = 3
);
  logic              ready;
  logic              start_song;
  logic              stop_song;
  logic              pause_song;
  logic              record_mode;
  logic              loop_mode;
  logic [SLOT_W-1:0] song_choice;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_we;
  logic              busy;
  logic              song_done;
  logic              done_pulse;
  logic              invalid_choice;
  logic [ADDR_W-1:0] song_length;

  modport master (
    output ready, start_song, stop_song, pause_song, record_mode, loop_mode, song_choice,
    input  mem_address, mem_we, busy, song_done, done_pulse, invalid_choice, song_length
  );

  modport slave (
    input  ready, start_song, stop_song, pause_song, record_mode, loop_mode, song_choice,
    output mem_address, mem_we, busy, song_done, done_pulse, invalid_choice, song_length
  );
endinterface

// File: rtl/song_address_sequencer.sv
// Multi-slot record/playback word-address generator for the ZBT sample memory,
// with per-slot recorded lengths, loop playback, stop, pause and completion pulse.
module song_address_sequencer #(
  parameter int ADDR_W           = 19,
  parameter int NUM_SLOTS        = 6,
  parameter int SLOT_W           = 3,
  parameter int SLOT_WORDS       = 80000,
  parameter int SAMPLES_PER_WORD = 3
) (
  input logic                      clk,
  input logic                      reset,
  song_address_sequencer_if.slave  bus
);
  localparam int PHASE_W = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;
  localparam int IDX_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam longint MEM_WORDS = longint'(NUM_SLOTS) * longint'(SLOT_WORDS);

  if (MEM_WORDS > (longint'(1) << ADDR_W)) begin : g_bad_size
    $error("song slots do not fit in the ADDR_W address space");
  end
  if ((longint'(1) << SLOT_W) < longint'(NUM_SLOTS)) begin : g_bad_slot_w
    $error("SLOT_W too narrow for NUM_SLOTS");
  end
  if (SAMPLES_PER_WORD < 1) begin : g_bad_spw
    $error("SAMPLES_PER_WORD must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, REC, PLAY, DONE} state_t;
  typedef logic [ADDR_W-1:0] addr_t;

  state_t             state, state_next;
  addr_t              mem_address;
  logic [SLOT_W-1:0]  sel;
  logic [PHASE_W-1:0] phase;
  addr_t              len [NUM_SLOTS];
  logic               done_pulse, invalid_choice;
  logic               done_next, invalid_next;

  function automatic addr_t slot_base(input logic [SLOT_W-1:0] k);
    return addr_t'(32'(k) * 32'(SLOT_WORDS));
  endfunction

  logic             choice_valid, active, advance, word_step, rec_last, play_more;
  logic [IDX_W-1:0] choice_idx, sel_idx;
  addr_t            base_sel, off, len_sel;

  assign choice_valid = 32'(bus.song_choice) < 32'(NUM_SLOTS);
  assign choice_idx   = choice_valid ? IDX_W'(bus.song_choice) : '0;
  assign sel_idx      = IDX_W'(sel);
  assign base_sel     = slot_base(sel);
  assign off          = mem_address - base_sel;
  assign len_sel      = len[sel_idx];
  assign active       = (state == REC) || (state == PLAY);
  assign advance      = bus.ready & ~bus.pause_song & active;
  assign word_step    = advance && (phase == PHASE_W'(SAMPLES_PER_WORD - 1));
  assign rec_last     = off == addr_t'(SLOT_WORDS - 1);
  assign play_more    = (off + addr_t'(1)) < len_sel;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_next   = state;
    done_next    = 1'b0;
    invalid_next = 1'b0;
    if (bus.start_song) begin
      if (!choice_valid) begin
        state_next   = IDLE;
        invalid_next = 1'b1;
      end else if (bus.record_mode) begin
        state_next = REC;
      end else if (len[choice_idx] != '0) begin
        state_next = PLAY;
      end else begin
        state_next = DONE;
        done_next  = 1'b1;
      end
    end else if (bus.stop_song && active) begin
      state_next = IDLE;
    end else if (word_step) begin
      if ((state == REC && rec_last) ||
          (state == PLAY && !play_more && !bus.loop_mode)) begin
        state_next = DONE;
        done_next  = 1'b1;
      end
    end
  end

  always_comb begin
    bus.mem_we         = (state == REC);
    bus.busy           = active;
    bus.song_done      = (state == IDLE) || (state == DONE);
    bus.mem_address    = mem_address;
    bus.done_pulse     = done_pulse;
    bus.invalid_choice = invalid_choice;
    bus.song_length    = len_sel;
  end

  // NOTE: the length table is reset explicitly, so a slot never recorded always reads as empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_address    <= '0;
      sel            <= '0;
      phase          <= '0;
      done_pulse     <= 1'b0;
      invalid_choice <= 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++) len[k] <= '0;
    end else begin
      done_pulse     <= done_next;
      invalid_choice <= invalid_next;
      if (bus.start_song) begin
        if (choice_valid) begin
          sel         <= bus.song_choice;
          mem_address <= slot_base(bus.song_choice);
          phase       <= '0;
          if (bus.record_mode) len[choice_idx] <= '0;
        end
      end else if (bus.stop_song && active) begin
        // Abort keeps address and lengths; the next start re-seeds both.
      end else if (advance) begin
        phase <= word_step ? '0 : phase + PHASE_W'(1);
        if (word_step) begin
          if (state == REC) begin
            len[sel_idx] <= len_sel + addr_t'(1);
            if (!rec_last) mem_address <= mem_address + addr_t'(1);
          end else if (play_more) begin
            mem_address <= mem_address + addr_t'(1);
          end else if (bus.loop_mode) begin
            mem_address <= base_sel;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_song_address_sequencer.sv
// Directed and random checks of the song address sequencer against a
// strobe-count model that derives address and length arithmetically.
module tb_song_address_sequencer;
  localparam int ADDR_W = 6, NUM_SLOTS = 4, SLOT_W = 3, SLOT_WORDS = 8, SPW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  song_address_sequencer_if #(.ADDR_W(ADDR_W), .SLOT_W(SLOT_W)) bus ();

  song_address_sequencer #(
    .ADDR_W(ADDR_W), .NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W),
    .SLOT_WORDS(SLOT_WORDS), .SAMPLES_PER_WORD(SPW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef enum {M_IDLE, M_REC, M_PLAY, M_DONE} mstate_t;
  mstate_t m_state;
  int      m_len [NUM_SLOTS];
  int      m_sel, m_n, m_addr;
  bit      m_done, m_inv;
  int      n_checks = 0, n_fail = 0;
  string   ctx = "init";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s: observed %0d expected %0d", ctx, tag, obs, exp);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    foreach (m_len[k]) m_len[k] = 0;
    m_sel = 0; m_n = 0; m_addr = 0; m_done = 0; m_inv = 0;
  endtask

  // Expected values follow from the number of accepted strobes since start.
  task automatic model_clock(input bit st, sp, rdy, ps, rec, lp, input int ch);
    int words, base;
    bit act;
    m_done = 0; m_inv = 0;
    act = (m_state == M_REC) || (m_state == M_PLAY);
    if (st) begin
      if (ch >= NUM_SLOTS) begin
        m_inv = 1; m_state = M_IDLE;
      end else begin
        m_sel = ch; m_n = 0; m_addr = ch * SLOT_WORDS;
        if (rec) begin m_len[ch] = 0; m_state = M_REC; end
        else if (m_len[ch] != 0) m_state = M_PLAY;
        else begin m_state = M_DONE; m_done = 1; end
      end
    end else if (sp && act) begin
      m_state = M_IDLE;
    end else if (rdy && !ps && act) begin
      m_n++;
      words = m_n / SPW;
      base  = m_sel * SLOT_WORDS;
      if (m_state == M_REC) begin
        m_len[m_sel] = words;
        m_addr = base + min2(words, SLOT_WORDS - 1);
        if (words == SLOT_WORDS) begin m_state = M_DONE; m_done = 1; end
      end else if (lp) begin
        m_addr = base + words % m_len[m_sel];
      end else begin
        m_addr = base + min2(words, m_len[m_sel] - 1);
        if (words >= m_len[m_sel]) begin m_state = M_DONE; m_done = 1; end
      end
    end
  endtask

  task automatic check_all();
    check("mem_address",    bus.mem_address,    m_addr);
    check("mem_we",         bus.mem_we,         m_state == M_REC);
    check("busy",           bus.busy,           m_state inside {M_REC, M_PLAY});
    check("song_done",      bus.song_done,      m_state inside {M_IDLE, M_DONE});
    check("done_pulse",     bus.done_pulse,     m_done);
    check("invalid_choice", bus.invalid_choice, m_inv);
    check("song_length",    bus.song_length,    m_len[m_sel]);
  endtask

  task automatic cycle(input bit st, sp, rdy, ps, rec, lp, input int ch);
    bus.start_song  = st;
    bus.stop_song   = sp;
    bus.ready       = rdy;
    bus.pause_song  = ps;
    bus.record_mode = rec;
    bus.loop_mode   = lp;
    bus.song_choice = SLOT_W'(ch);
    @(posedge clk);
    #1;
    model_clock(st, sp, rdy, ps, rec, lp, ch);
    bus.start_song = 1'b0;
    bus.stop_song  = 1'b0;
    bus.ready      = 1'b0;
    check_all();
  endtask

  task automatic pulses(input int n, input bit lp);
    repeat (n) begin
      cycle(0, 0, 1, 0, 0, lp, 0);
      cycle(0, 0, 0, 0, 0, lp, 0);
    end
  endtask

  initial begin
    bit st, sp, rdy, ps, rec, lp;
    int ch;
    reset = 1'b1;
    bus.ready = 0; bus.start_song = 0; bus.stop_song = 0; bus.pause_song = 0;
    bus.record_mode = 0; bus.loop_mode = 0; bus.song_choice = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ctx = "reset";
    check_all();

    ctx = "t1_async_reset";
    cycle(1, 0, 0, 0, 1, 0, 3);
    pulses(4, 0);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #1 reset = 1'b0;
    cycle(1, 0, 0, 0, 0, 0, 3);
    check("done_direct", bus.done_pulse, 1'b1);

    ctx = "t2_record";
    cycle(1, 0, 0, 0, 1, 0, 2);
    pulses(9, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    check("addr_direct", bus.mem_address, 19);
    check("len_direct",  bus.song_length, 3);

    ctx = "t3_play";
    cycle(1, 0, 0, 0, 0, 0, 2);
    pulses(9, 0);
    check("addr_direct", bus.mem_address, 18);
    pulses(3, 0);

    ctx = "t4_loop";
    cycle(1, 0, 0, 0, 0, 1, 2);
    pulses(12, 1);
    check("addr_direct", bus.mem_address, 17);

    ctx = "t5_full_record";
    cycle(1, 0, 0, 0, 1, 0, 1);
    pulses(30, 0);
    check("addr_direct", bus.mem_address, 15);
    check("len_direct",  bus.song_length, 8);

    ctx = "t6_pause";
    cycle(1, 0, 0, 0, 0, 0, 2);
    pulses(2, 0);
    repeat (4) cycle(0, 0, 1, 1, 0, 0, 0);
    ctx = "t6_invalid";
    cycle(1, 0, 0, 0, 1, 0, 5);
    check("inv_direct", bus.invalid_choice, 1'b1);
    ctx = "t6_start_stop";
    cycle(1, 1, 0, 0, 0, 0, 2);
    check("busy_direct", bus.busy, 1'b1);

    ctx = "random";
    lp = 0;
    repeat (600) begin
      st  = ($urandom_range(15) == 0);
      sp  = ($urandom_range(15) == 0);
      rdy = $urandom_range(1);
      ps  = ($urandom_range(7) == 0);
      rec = $urandom_range(1);
      ch  = $urandom_range(5);
      if (st) lp = $urandom_range(1);
      cycle(st, sp, rdy, ps, rec, lp, ch);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
